// File: rtl/oyun_hamle_toplayici_pkg.sv
// Shared types for the oyun move collector: FSM state codes, move payload and point table.
package oyun_hamle_toplayici_pkg;

  localparam int unsigned HAMLE_W      = 2;
  localparam int unsigned HAMLE_SAYISI = 6;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    TOPLA       = 2'd1,
    DEGERLENDIR = 2'd2,
    DONE        = 2'd3
  } durum_e;

  typedef struct packed {
    logic [HAMLE_W-1:0] x;
    logic [HAMLE_W-1:0] y;
  } hamle_t;

  // Point table indexed by {x,y}; any zero coordinate scores nothing.
  localparam logic [15:0][1:0] PUAN = {
    2'd1, 2'd2, 2'd1, 2'd0,   // x=3: y=3..0
    2'd2, 2'd3, 2'd2, 2'd0,   // x=2
    2'd1, 2'd2, 2'd1, 2'd0,   // x=1
    2'd0, 2'd0, 2'd0, 2'd0    // x=0
  };

  function automatic logic [1:0] puan(input logic [HAMLE_W-1:0] x, input logic [HAMLE_W-1:0] y);
    return PUAN[{x, y}];
  endfunction

endpackage

// File: rtl/oyun_hamle_toplayici_zaman_sayaci.sv
// Idle-cycle counter for the move timeout; saturates instead of wrapping.
module oyun_hamle_toplayici_zaman_sayaci #(
  parameter int unsigned SAYAC_W     = 10,
  parameter int unsigned ZAMAN_ASIMI = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic dolu
);

  logic [SAYAC_W-1:0] sayac_q;

  // The current cycle is the ZAMAN_ASIMI-th idle one once the count reaches ZAMAN_ASIMI-1.
  assign dolu = (sayac_q >= SAYAC_W'(ZAMAN_ASIMI - 1));

  // Count idle cycles, hold at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      sayac_q <= '0;
    end else if (en && (sayac_q != '1)) begin
      sayac_q <= sayac_q + SAYAC_W'(1);
    end
  end

endmodule

// File: rtl/oyun_hamle_toplayici.sv
// Sequential front end for the oyun evaluator: collects six ordered moves,
// enforces turn order and timeout, and latches the evaluator's verdict.
module oyun_hamle_toplayici
  import oyun_hamle_toplayici_pkg::*;
#(
  parameter int unsigned SAYAC_W     = 10,
  parameter int unsigned ZAMAN_ASIMI = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               basla,
  input  logic               hamle_valid,
  input  logic               hamle_oyuncu,
  input  logic [HAMLE_W-1:0] hamle_x,
  input  logic [HAMLE_W-1:0] hamle_y,
  output logic               hamle_ready,
  output logic [HAMLE_W-1:0] X11,
  output logic [HAMLE_W-1:0] Y11,
  output logic [HAMLE_W-1:0] X21,
  output logic [HAMLE_W-1:0] Y21,
  output logic [HAMLE_W-1:0] X12,
  output logic [HAMLE_W-1:0] Y12,
  output logic [HAMLE_W-1:0] X22,
  output logic [HAMLE_W-1:0] Y22,
  output logic [HAMLE_W-1:0] X13,
  output logic [HAMLE_W-1:0] Y13,
  output logic [HAMLE_W-1:0] X23,
  output logic [HAMLE_W-1:0] Y23,
  input  logic               oyun_o,
  output logic [1:0]         tur,
  output logic               sira,
  output logic               sonuc_valid,
  output logic               sonuc,
  output logic               sira_hatasi,
  output logic               zaman_asimi
);

  durum_e     state_q;
  hamle_t     hamle_q [HAMLE_SAYISI];
  logic [1:0] tur_q;
  logic       sira_q;
  logic       ready_q;
  logic       sonuc_q;
  logic       sonuc_valid_q;
  logic       sira_hatasi_q;
  logic       zaman_asimi_q;

  logic       kabul_c;
  logic       dogru_c;
  logic       son_hamle_c;
  logic [2:0] slot_c;
  logic       dolu;

  // Handshake decode; slot index is {round-1, player}, giving P1R1,P2R1,P1R2,...
  always_comb begin
    kabul_c     = hamle_valid && ready_q;
    dogru_c     = kabul_c && (hamle_oyuncu == sira_q);
    son_hamle_c = (tur_q == 2'd3) && sira_q;
    slot_c      = {2'(tur_q - 2'd1), sira_q};
  end

  oyun_hamle_toplayici_zaman_sayaci #(
    .SAYAC_W    (SAYAC_W),
    .ZAMAN_ASIMI(ZAMAN_ASIMI)
  ) u_zaman_sayaci (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  ((state_q != TOPLA) || dogru_c),
    .en   (state_q == TOPLA),
    .dolu (dolu)
  );

  // Game FSM with move storage, result latch and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      tur_q         <= 2'd0;
      sira_q        <= 1'b0;
      ready_q       <= 1'b0;
      sonuc_q       <= 1'b0;
      sonuc_valid_q <= 1'b0;
      sira_hatasi_q <= 1'b0;
      zaman_asimi_q <= 1'b0;
      for (int i = 0; i < int'(HAMLE_SAYISI); i++) hamle_q[i] <= '0;
    end else begin
      sira_hatasi_q <= 1'b0;
      zaman_asimi_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (basla) begin
            state_q       <= TOPLA;
            tur_q         <= 2'd1;
            sira_q        <= 1'b0;
            ready_q       <= 1'b1;
            sonuc_q       <= 1'b0;
            sonuc_valid_q <= 1'b0;
            for (int i = 0; i < int'(HAMLE_SAYISI); i++) hamle_q[i] <= '0;
          end else if (state_q == DONE) begin
            // Flag the result one cycle after it was latched.
            sonuc_valid_q <= 1'b1;
          end
        end
        TOPLA: begin
          if (dogru_c) begin
            for (int i = 0; i < int'(HAMLE_SAYISI); i++) begin
              if (slot_c == 3'(i)) hamle_q[i] <= '{x: hamle_x, y: hamle_y};
            end
            if (son_hamle_c) begin
              state_q <= DEGERLENDIR;
              tur_q   <= 2'd0;
              sira_q  <= 1'b0;
              ready_q <= 1'b0;
            end else begin
              sira_q <= ~sira_q;
              if (sira_q) tur_q <= tur_q + 2'd1;
            end
          end else begin
            if (kabul_c) sira_hatasi_q <= 1'b1;
            if (dolu) begin
              state_q       <= IDLE;
              tur_q         <= 2'd0;
              sira_q        <= 1'b0;
              ready_q       <= 1'b0;
              zaman_asimi_q <= 1'b1;
              for (int i = 0; i < int'(HAMLE_SAYISI); i++) hamle_q[i] <= '0;
            end
          end
        end
        DEGERLENDIR: begin
          sonuc_q <= oyun_o;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hamle_ready = ready_q;
  assign tur         = tur_q;
  assign sira        = sira_q;
  assign sonuc       = sonuc_q;
  assign sonuc_valid = sonuc_valid_q;
  assign sira_hatasi = sira_hatasi_q;
  assign zaman_asimi = zaman_asimi_q;

  assign X11 = hamle_q[0].x;
  assign Y11 = hamle_q[0].y;
  assign X21 = hamle_q[1].x;
  assign Y21 = hamle_q[1].y;
  assign X12 = hamle_q[2].x;
  assign Y12 = hamle_q[2].y;
  assign X22 = hamle_q[3].x;
  assign Y22 = hamle_q[3].y;
  assign X13 = hamle_q[4].x;
  assign Y13 = hamle_q[4].y;
  assign X23 = hamle_q[5].x;
  assign Y23 = hamle_q[5].y;

endmodule

// File: tb/tb_oyun_hamle_toplayici.sv
// Directed bench for oyun_hamle_toplayici with a behavioural oyun evaluator.
module tb_oyun_hamle_toplayici;
  import oyun_hamle_toplayici_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       basla;
  logic       hamle_valid;
  logic       hamle_oyuncu;
  logic [1:0] hamle_x;
  logic [1:0] hamle_y;
  logic       hamle_ready;
  logic [1:0] X11, Y11, X21, Y21, X12, Y12, X22, Y22, X13, Y13, X23, Y23;
  logic       oyun_o;
  logic [1:0] tur;
  logic       sira;
  logic       sonuc_valid;
  logic       sonuc;
  logic       sira_hatasi;
  logic       zaman_asimi;
  logic [23:0] xy_all;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  oyun_hamle_toplayici #(.SAYAC_W(10), .ZAMAN_ASIMI(1000)) dut (
    .clk(clk), .rst_n(rst_n), .basla(basla),
    .hamle_valid(hamle_valid), .hamle_oyuncu(hamle_oyuncu),
    .hamle_x(hamle_x), .hamle_y(hamle_y), .hamle_ready(hamle_ready),
    .X11(X11), .Y11(Y11), .X21(X21), .Y21(Y21),
    .X12(X12), .Y12(Y12), .X22(X22), .Y22(Y22),
    .X13(X13), .Y13(Y13), .X23(X23), .Y23(Y23),
    .oyun_o(oyun_o), .tur(tur), .sira(sira),
    .sonuc_valid(sonuc_valid), .sonuc(sonuc),
    .sira_hatasi(sira_hatasi), .zaman_asimi(zaman_asimi)
  );

  assign xy_all = {X11, Y11, X21, Y21, X12, Y12, X22, Y22, X13, Y13, X23, Y23};

  // Behavioural oyun: 1 when at least two rounds have point sum >= 5.
  logic [2:0] r1, r2, r3;
  always_comb begin
    r1 = 3'(puan(X11, Y11)) + 3'(puan(X21, Y21));
    r2 = 3'(puan(X12, Y12)) + 3'(puan(X22, Y22));
    r3 = 3'(puan(X13, Y13)) + 3'(puan(X23, Y23));
    oyun_o = ((r1 >= 3'd5) && (r2 >= 3'd5)) ||
             ((r1 >= 3'd5) && (r3 >= 3'd5)) ||
             ((r2 >= 3'd5) && (r3 >= 3'd5));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hamle(input logic p, input logic [1:0] x, input logic [1:0] y);
    hamle_valid  = 1'b1;
    hamle_oyuncu = p;
    hamle_x      = x;
    hamle_y      = y;
    step();
    hamle_valid  = 1'b0;
  endtask

  task automatic basla_pulse();
    basla = 1'b1;
    step();
    basla = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; basla = 1'b0; hamle_valid = 1'b0;
    hamle_oyuncu = 1'b0; hamle_x = 2'd0; hamle_y = 2'd0;
    step(); step();
    chk("rst_ready", 32'(hamle_ready), 32'd0);
    chk("rst_tur", 32'(tur), 32'd0);
    chk("rst_sira", 32'(sira), 32'd0);
    chk("rst_valid", 32'(sonuc_valid), 32'd0);
    chk("rst_sonuc", 32'(sonuc), 32'd0);
    chk("rst_xy", 32'(xy_all), 32'd0);
    chk("rst_pulses", 32'({sira_hatasi, zaman_asimi}), 32'd0);

    // Game 1: all (2,2)
    rst_n = 1'b1;
    basla_pulse();
    chk("g1_ready", 32'(hamle_ready), 32'd1);
    chk("g1_tur", 32'(tur), 32'd1);
    chk("g1_sira", 32'(sira), 32'd0);
    for (int i = 0; i < 6; i++) hamle(1'(i % 2), 2'd2, 2'd2);
    chk("g1_n_ready", 32'(hamle_ready), 32'd0);
    chk("g1_n_tur", 32'(tur), 32'd0);
    chk("g1_n_valid", 32'(sonuc_valid), 32'd0);
    chk("g1_xy", 32'(xy_all), 32'hAAAAAA);
    step();
    chk("g1_n1_valid", 32'(sonuc_valid), 32'd0);
    step();
    chk("g1_n2_valid", 32'(sonuc_valid), 32'd1);
    chk("g1_sonuc", 32'(sonuc), 32'd1);

    // Restart from DONE, game 2: sums 5, 2, 1
    basla_pulse();
    chk("g2_valid_clr", 32'(sonuc_valid), 32'd0);
    chk("g2_sonuc_clr", 32'(sonuc), 32'd0);
    chk("g2_tur", 32'(tur), 32'd1);
    chk("g2_xy_clr", 32'(xy_all), 32'd0);
    hamle(1'b0, 2'd2, 2'd2); hamle(1'b1, 2'd1, 2'd2);
    chk("g2_tur2", 32'(tur), 32'd2);
    hamle(1'b0, 2'd1, 2'd1); hamle(1'b1, 2'd1, 2'd1);
    hamle(1'b0, 2'd0, 2'd3);
    chk("g2_sira", 32'(sira), 32'd1);
    hamle(1'b1, 2'd3, 2'd3);
    step(); step();
    chk("g2_xy", 32'(xy_all), 32'hA6553F);
    chk("g2_valid", 32'(sonuc_valid), 32'd1);
    chk("g2_sonuc", 32'(sonuc), 32'd0);

    // Game 3: P2 jumps the queue in round 1
    basla_pulse();
    hamle(1'b1, 2'd3, 2'd1);
    chk("g3_hata", 32'(sira_hatasi), 32'd1);
    chk("g3_sira", 32'(sira), 32'd0);
    chk("g3_tur", 32'(tur), 32'd1);
    chk("g3_x21", 32'({X21, Y21}), 32'd0);
    step();
    chk("g3_hata_end", 32'(sira_hatasi), 32'd0);
    hamle(1'b0, 2'd2, 2'd2); hamle(1'b1, 2'd2, 2'd2);
    hamle(1'b0, 2'd2, 2'd2); hamle(1'b1, 2'd1, 2'd2);
    hamle(1'b0, 2'd1, 2'd1); hamle(1'b1, 2'd0, 2'd0);
    step(); step();
    chk("g3_valid", 32'(sonuc_valid), 32'd1);
    chk("g3_sonuc", 32'(sonuc), 32'd1);

    // Game 4: timeout after three moves
    basla_pulse();
    hamle(1'b0, 2'd1, 2'd3); hamle(1'b1, 2'd2, 2'd1); hamle(1'b0, 2'd3, 2'd2);
    for (int i = 0; i < 999; i++) step();
    chk("g4_pre_ready", 32'(hamle_ready), 32'd1);
    chk("g4_pre_to", 32'(zaman_asimi), 32'd0);
    step();
    chk("g4_to", 32'(zaman_asimi), 32'd1);
    chk("g4_ready", 32'(hamle_ready), 32'd0);
    chk("g4_xy", 32'(xy_all), 32'd0);
    chk("g4_tur", 32'(tur), 32'd0);
    step();
    chk("g4_to_end", 32'(zaman_asimi), 32'd0);

    // Moves are ignored in IDLE
    hamle(1'b0, 2'd3, 2'd3);
    chk("idle_xy", 32'(xy_all), 32'd0);
    chk("idle_ready", 32'(hamle_ready), 32'd0);

    // Game 5: basla in TOPLA ignored, reset mid-game, then full game
    basla_pulse();
    hamle(1'b0, 2'd1, 2'd1);
    basla_pulse();
    chk("g5_basla_tur", 32'(tur), 32'd1);
    chk("g5_basla_sira", 32'(sira), 32'd1);
    hamle(1'b1, 2'd1, 2'd2); hamle(1'b0, 2'd2, 2'd1); hamle(1'b1, 2'd3, 2'd3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("g5_rst_xy", 32'(xy_all), 32'd0);
    chk("g5_rst_state", 32'({hamle_ready, tur, sira, sonuc_valid, sonuc}), 32'd0);
    basla_pulse();
    hamle(1'b0, 2'd2, 2'd2); hamle(1'b1, 2'd2, 2'd2);
    hamle(1'b0, 2'd2, 2'd2); hamle(1'b1, 2'd2, 2'd2);
    hamle(1'b0, 2'd0, 2'd0); hamle(1'b1, 2'd0, 2'd0);
    step(); step();
    chk("g5_xy", 32'(xy_all), 32'hAAAA00);
    chk("g5_valid", 32'(sonuc_valid), 32'd1);
    chk("g5_sonuc", 32'(sonuc), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
